// File: rtl/test_udiv_128ns_64ns_64_seq_if.sv
// Start/done handshake and operand/result bus of the 128/64 sequential divider.
interface test_udiv_128ns_64ns_64_seq_if #(
    parameter int din0_WIDTH = 128,
    parameter int din1_WIDTH = 64,
    parameter int dout_WIDTH = 64
);
    logic                  ce;
    logic                  start;
    logic [din0_WIDTH-1:0] din0;
    logic [din1_WIDTH-1:0] din1;
    logic                  ready;
    logic                  done;
    logic                  err;
    logic [dout_WIDTH-1:0] quot;
    logic [dout_WIDTH-1:0] rem;

    modport master (
        output ce, start, din0, din1,
        input  ready, done, err, quot, rem
    );

    modport slave (
        input  ce, start, din0, din1,
        output ready, done, err, quot, rem
    );
endinterface

// File: rtl/test_udiv_128ns_64ns_64_seq.sv
// Radix-2 restoring divider, 128-bit dividend / 64-bit divisor, one quotient bit per enabled edge.
//
//   state | meaning
//   IDLE  | ready=1, waiting for start; accepting edge loads operands or flags error
//   CALC  | one restoring step per enabled edge, NUM_STAGE steps
//   DONE  | done=1 for one enabled cycle, then back to IDLE
module test_udiv_128ns_64ns_64_seq #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 64,
    parameter int din0_WIDTH = 128,
    parameter int din1_WIDTH = 64,
    parameter int dout_WIDTH = 64
) (
    input  logic ap_clk,
    input  logic ap_rst,
    test_udiv_128ns_64ns_64_seq_if.slave bus
);
    localparam int W  = dout_WIDTH;
    localparam int CW = $clog2(NUM_STAGE);

    if (NUM_STAGE != dout_WIDTH || din0_WIDTH != 2 * din1_WIDTH ||
        dout_WIDTH != din1_WIDTH || ID < 0) begin : g_bad_param
        $error("test_udiv_128ns_64ns_64_seq: inconsistent width parameters");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [W:0]     r;
    logic [W-1:0]   q;
    logic [W-1:0]   d;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   quot;
    logic [W-1:0]   rem;
    logic           err;

    logic [W:0]     t;
    logic           ge;
    logic [W:0]     r_nxt;
    logic [W-1:0]   q_nxt;
    logic           last;
    logic           ovf;
    logic           accept;

    // Quotient must fit in W bits: high half of dividend strictly below divisor.
    assign ovf    = (bus.din1 == '0) || (bus.din0[2*W-1:W] >= bus.din1);
    assign accept = (state == IDLE) && bus.start;
    assign last   = (cnt == CW'(NUM_STAGE - 1));

    assign t     = {r[W-1:0], q[W-1]};
    assign ge    = (t >= {1'b0, d});
    assign r_nxt = ge ? (t - {1'b0, d}) : t;
    assign q_nxt = {q[W-2:0], ge};

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state <= IDLE;
        end else if (bus.ce) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = ovf ? DONE : CALC;
            CALC:    if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.ready = (state == IDLE);
        bus.done  = (state == DONE);
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r    <= '0;
            q    <= '0;
            d    <= '0;
            cnt  <= '0;
            quot <= '0;
            rem  <= '0;
            err  <= 1'b0;
        end else if (bus.ce) begin
            if (accept) begin
                if (ovf) begin
                    err  <= 1'b1;
                    quot <= '1;
                    rem  <= '0;
                end else begin
                    r   <= {1'b0, bus.din0[2*W-1:W]};
                    q   <= bus.din0[W-1:0];
                    d   <= bus.din1;
                    cnt <= '0;
                    err <= 1'b0;
                end
            end else if (state == CALC) begin
                r   <= r_nxt;
                q   <= q_nxt;
                cnt <= cnt + 1'b1;
                if (last) begin
                    quot <= q_nxt;
                    rem  <= r_nxt[W-1:0];
                end
            end
        end
    end

    assign bus.quot = quot;
    assign bus.rem  = rem;
    assign bus.err  = err;
endmodule
